// File: rtl/mem_arb.sv
// mem_arb: shares one single-ported RAM between an instruction fetch port
// and a data load/store port.
// Each access is one IDLE cycle that latches the grant, followed by one or
// more ACC cycles that end when the RAM reports ram_rdy.
// The RAM-side strobes and the requester wait/load outputs are driven
// combinationally from the state and the live requester inputs. This lets a
// requester that drops its request abort the access in the same cycle.
// If an access sees no ram_rdy for TMO consecutive ACC cycles, the arbiter
// locks into ERR and raises tmo_err. Only reset leaves ERR.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requests. Without it, data requests always win.
module mem_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TMO    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_rdy,
    output logic              tmo_err
);

    localparam int CNT_W = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tmo_flag;

    logic dreq;       // data side wants the RAM (read, write, or both = write)
    logic grant_d;    // arbitration result when leaving IDLE
    logic acc_live;   // granted requester still asserting its request
    logic i_done;     // fetch completes this cycle
    logic d_done;     // data access completes this cycle

`ifdef MEM_ARB_RR_EN
    logic last_i;     // 1 = the fetch side was the last one served

    // On a conflict, the side that was not served last wins
    always_comb begin
        grant_d = dreq & (~iREN | last_i);
    end
`else
    // Fixed priority: any data request beats a simultaneous fetch
    always_comb begin
        grant_d = dreq;
    end
`endif

    // Decode request liveness and completion strobes
    always_comb begin
        dreq     = dREN | dWEN;
        acc_live = 1'b0;
        if (state == IACC) begin
            acc_live = iREN;
        end else if (state == DACC) begin
            acc_live = dreq;
        end
        i_done = (state == IACC) & iREN & ram_rdy;
        d_done = (state == DACC) & dreq & ram_rdy;
    end

    // Arbitration FSM with timeout counter and sticky error flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            tmo_flag <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_i   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        state <= DACC;
                    end else if (iREN) begin
                        state <= IACC;
                    end
                end
                IACC, DACC: begin
                    if (!acc_live) begin
                        // Requester withdrew: abandon the access without completing it
                        state <= IDLE;
                    end else if (ram_rdy) begin
                        state <= IDLE;
`ifdef MEM_ARB_RR_EN
                        last_i <= (state == IACC);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state    <= ERR;
                            tmo_flag <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM strobes and requester handshakes, driven from state and live inputs
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IACC: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DACC: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
        iwait   = iREN & ~i_done;
        dwait   = dreq & ~d_done;
        iload   = i_done ? ramload : '0;
        dload   = d_done ? ramload : '0;
        tmo_err = tmo_flag;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb. Directed vectors are used. Each expected completion
// is pushed into a scoreboard queue when its stimulus is issued. A separate
// monitor pops an entry and compares it whenever a requester sees its wait
// drop while still requesting. Cycle-accurate wait, strobe and error-flag
// expectations are checked inline.
module tb_mem_arb;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN, dREN, dWEN, ram_rdy;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore, ramload;
    logic [DW-1:0] iload, dload, ramstore;
    logic [AW-1:0] ramaddr;
    logic          iwait, dwait, ramREN, ramWEN, tmo_err;

    typedef struct {
        bit          is_d;
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] store;
        bit          chk_store;
        logic        ren;
        logic        wen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_arb #(.DATA_W(DW), .ADDR_W(AW), .TMO(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_rdy(ram_rdy),
        .tmo_err(tmo_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic observe(input bit is_d);
        exp_t        e;
        logic [31:0] ld, other;
        bit          bad;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_completion: side=%0d got load=%h, expected no completion (t=%0t)",
                     is_d, is_d ? dload : iload, $time);
        end else begin
            e     = sb.pop_front();
            ld    = is_d ? dload : iload;
            other = is_d ? iload : dload;
            bad   = (e.is_d != is_d) || (ld !== e.load) || (ramaddr !== e.addr) ||
                    (ramREN !== e.ren) || (ramWEN !== e.wen) || (other !== 32'h0) ||
                    (e.chk_store && (ramstore !== e.store));
            if (bad) begin
                errors++;
                $display("FAIL completion: got side=%0d load=%h addr=%h store=%h ren=%b wen=%b other_load=%h, expected side=%0d load=%h addr=%h store=%h ren=%b wen=%b other_load=0",
                         is_d, ld, ramaddr, ramstore, ramREN, ramWEN, other,
                         e.is_d, e.load, e.addr, e.store, e.ren, e.wen);
            end else begin
                $display("ok   completion: side=%0d load=%h addr=%h (t=%0t)", is_d, ld, ramaddr, $time);
            end
        end
    endtask

    // Monitor: a completion is a requester whose wait is low while it still requests
    always @(negedge CLK) begin
        if (!RST) begin
            if (iREN && !iwait) observe(1'b0);
            if ((dREN || dWEN) && !dwait) observe(1'b1);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t mk(input bit is_d, input logic [31:0] ld, input logic [31:0] ad,
                                input logic [31:0] st, input bit cs, input logic ren,
                                input logic wen);
        exp_t e;
        e.is_d = is_d; e.load = ld; e.addr = ad; e.store = st;
        e.chk_store = cs; e.ren = ren; e.wen = wen;
        return e;
    endfunction

    // Simultaneous fetch and write; d_first selects which side should win
    task automatic conflict(input bit d_first, input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] ds, input logic [31:0] ld, input bit both);
        exp_t ed, ei;
        step();
        iREN = 1'b1; iaddr = ia;
        dWEN = 1'b1; dREN = both; daddr = da; dstore = ds;
        ram_rdy = 1'b1; ramload = ld;
        ed = mk(1'b1, ld, da, ds, 1'b1, 1'b0, 1'b1);
        ei = mk(1'b0, ld, ia, 32'h0, 1'b0, 1'b1, 1'b0);
        if (d_first) begin
            sb.push_back(ed); sb.push_back(ei);
        end else begin
            sb.push_back(ei); sb.push_back(ed);
        end
        @(negedge CLK);
        chk("conf_idle_iwait", iwait, 1);
        chk("conf_idle_dwait", dwait, 1);
        step();
        @(negedge CLK);
        chk("conf_first_done", d_first ? dwait : iwait, 0);
        chk("conf_other_held", d_first ? iwait : dwait, 1);
        step();
        if (d_first) begin
            dWEN = 1'b0; dREN = 1'b0;
        end else begin
            iREN = 1'b0;
        end
        @(negedge CLK);
        chk("conf_bubble_wait", d_first ? iwait : dwait, 1);
        chk("conf_bubble_ram", {ramREN, ramWEN}, 0);
        step();
        @(negedge CLK);
        chk("conf_second_done", d_first ? iwait : dwait, 0);
        step();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ram_rdy = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hFFFF_FFFF;

        // Reset: outputs are zero except the waits, which follow the requests
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_loads", {iload, dload}, 0);
        chk("rst_tmo_err", tmo_err, 0);
        iREN = 1'b0; dREN = 1'b0;
        step();
        RST = 1'b0;

        // Fetch only: wait drops on the second cycle
        step();
        iREN = 1'b1; iaddr = 32'h40; ram_rdy = 1'b1; ramload = 32'h8C01_0004;
        sb.push_back(mk(1'b0, 32'h8C01_0004, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0));
        @(negedge CLK);
        chk("f_idle_iwait", iwait, 1);
        chk("f_idle_ramREN", ramREN, 0);
        chk("f_idle_iload", iload, 0);
        step();
        @(negedge CLK);
        chk("f_done_iwait", iwait, 0);
        step();
        iREN = 1'b0;

        // Conflict: fetch was served last (and reset says the same), so data wins
        conflict(1'b1, 32'h44, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);

        // Data read with three wait states: dwait drops on cycle 5
        step();
        dREN = 1'b1; daddr = 32'h200; dstore = 32'h0; ram_rdy = 1'b0; ramload = 32'hCAFE_F00D;
        sb.push_back(mk(1'b1, 32'hCAFE_F00D, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0));
        @(negedge CLK);
        chk("ws_c1_dwait", dwait, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLK);
            chk("ws_dwait", dwait, 1);
            chk("ws_dload", dload, 0);
            chk("ws_ramREN", ramREN, 1);
        end
        step();
        ram_rdy = 1'b1;
        @(negedge CLK);
        chk("ws_c5_dwait", dwait, 0);
        step();
        dREN = 1'b0;

        // Second conflict with dREN&dWEN (a write); data was served last
`ifdef MEM_ARB_RR_EN
        conflict(1'b0, 32'h48, 32'h104, 32'h1234_5678, 32'h2222_2222, 1'b1);
`else
        conflict(1'b1, 32'h48, 32'h104, 32'h1234_5678, 32'h2222_2222, 1'b1);
`endif

        // Abort: drop dREN mid-DACC; a fetch raised at the same time needs a fresh IDLE
        step();
        dREN = 1'b1; daddr = 32'h300; ram_rdy = 1'b0;
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("ab_dacc_ramREN", ramREN, 1);
        step();
        dREN = 1'b0; iREN = 1'b1; iaddr = 32'h50; ram_rdy = 1'b1; ramload = 32'h55AA_55AA;
        sb.push_back(mk(1'b0, 32'h55AA_55AA, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0));
        @(negedge CLK);
        chk("ab_ramREN", ramREN, 0);
        chk("ab_dwait", dwait, 0);
        chk("ab_dload", dload, 0);
        chk("ab_iwait", iwait, 1);
        step();
        @(negedge CLK);
        chk("ab_idle_iwait", iwait, 1);
        chk("ab_idle_ramREN", ramREN, 0);
        step();
        @(negedge CLK);
        chk("ab_fetch_iwait", iwait, 0);
        step();
        iREN = 1'b0;

        // Reset in the middle of a fetch, then a fresh fetch
        step();
        iREN = 1'b1; iaddr = 32'h60; ram_rdy = 1'b0;
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("rm_ramREN", ramREN, 1);
        chk("rm_ramaddr", ramaddr, 32'h60);
        #2;
        RST = 1'b1;
        #1;
        chk("rm_rst_ramREN", ramREN, 0);
        chk("rm_rst_ramaddr", ramaddr, 0);
        chk("rm_rst_iwait", iwait, 1);
        step();
        @(negedge CLK);
        step();
        RST = 1'b0; iaddr = 32'h64; ram_rdy = 1'b1; ramload = 32'h0BAD_F00D;
        sb.push_back(mk(1'b0, 32'h0BAD_F00D, 32'h64, 32'h0, 1'b0, 1'b1, 1'b0));
        @(negedge CLK);
        chk("rm_idle_iwait", iwait, 1);
        step();
        @(negedge CLK);
        chk("rm_fetch_iwait", iwait, 0);
        step();
        iREN = 1'b0;

        // Timeout: four IACC cycles without ram_rdy, then ERR until reset
        step();
        iREN = 1'b1; iaddr = 32'h70; ram_rdy = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge CLK);
            chk("to_acc_tmo_err", tmo_err, 0);
            chk("to_acc_ramREN", ramREN, 1);
        end
        step();
        @(negedge CLK);
        chk("to_err_tmo_err", tmo_err, 1);
        chk("to_err_ramREN", ramREN, 0);
        chk("to_err_iwait", iwait, 1);
        step();
        iREN = 1'b0; dREN = 1'b1; daddr = 32'h80; ram_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("to_err_sticky", tmo_err, 1);
            chk("to_err_dwait", dwait, 1);
            chk("to_err_iwait_low", iwait, 0);
            chk("to_err_ram", {ramREN, ramWEN}, 0);
            step();
        end
        RST = 1'b1;
        #1;
        chk("to_rst_tmo_err", tmo_err, 0);
        chk("to_rst_dwait", dwait, 1);
        step();
        RST = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
